// File: rtl/rr_arbiter_reg_pkg.sv
// arb_pkg: FSM state encodings and rotation-mask helper shared by the arbiter files.
package arb_pkg;
  localparam int ARB_MAX_PORTS = 64;
  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;
  // Ports strictly after ptr in rotation order: above it when ascending, below when descending.
  function automatic logic [ARB_MAX_PORTS-1:0] rot_mask(input int ptr, input logic lsb_high);
    for (int i = 0; i < ARB_MAX_PORTS; i++) rot_mask[i] = lsb_high ? (i > ptr) : (i < ptr);
  endfunction
endpackage

// File: rtl/rr_arbiter_reg_if.sv
// rr_arbiter_reg_if: request/acknowledge/weight in, registered grant out.
interface rr_arbiter_reg_if #(parameter int PORTS = 4, parameter int WEIGHT_W = 4);
  logic [PORTS-1:0] request, acknowledge, grant;
  logic [PORTS*WEIGHT_W-1:0] weight;
  logic grant_valid;
  logic [$clog2(PORTS)-1:0] grant_encoded;
  modport master(output request, acknowledge, weight, input grant, grant_valid, grant_encoded);
  modport slave(input request, acknowledge, weight, output grant, grant_valid, grant_encoded);
endinterface

// File: rtl/rr_arbiter_reg_priority_encoder.sv
// priority_encoder: index of the highest-priority set request bit.
module priority_encoder #(parameter int PORTS = 4, parameter int LSB_HIGH_PRIORITY = 1) (
  input  logic [PORTS-1:0]         req,
  output logic [$clog2(PORTS)-1:0] idx,
  output logic                     valid
);
  localparam int IW = $clog2(PORTS);
  assign valid = |req;
  // Scan lowest priority first so the highest-priority hit is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = 0; i < PORTS; i++)
      if (req[LSB_HIGH_PRIORITY != 0 ? PORTS-1-i : i]) idx = IW'(LSB_HIGH_PRIORITY != 0 ? PORTS-1-i : i);
  end
endmodule

// File: rtl/rr_arbiter_reg.sv
// rr_arbiter_reg: registered round-robin/fixed-priority arbiter with grant lock.
// Define RR_ARBITER_REG_WEIGHT_EN for per-port weighted credits.
module rr_arbiter_reg import arb_pkg::*; #(
  parameter int PORTS = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int LSB_HIGH_PRIORITY = 1,
  parameter int WEIGHT_W = 4
) (
  input logic clk,
  input logic rst_n,
  rr_arbiter_reg_if.slave bus
);
  localparam int IW = $clog2(PORTS);
  localparam logic [IW-1:0] PTR_RST = LSB_HIGH_PRIORITY != 0 ? IW'(PORTS-1) : '0;
  arb_state_t state;
  logic [PORTS-1:0] grant_q, mask;
  logic [IW-1:0] enc_q, ptr, idx_m, idx_u, win;
  logic valid_q, any_m, any_u, last_credit, rel, load;
  assign mask = PORTS'(rot_mask(int'(ptr), LSB_HIGH_PRIORITY != 0));
  priority_encoder #(.PORTS(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_masked (
    .req(bus.request & mask), .idx(idx_m), .valid(any_m));
  priority_encoder #(.PORTS(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_full (
    .req(bus.request), .idx(idx_u), .valid(any_u));
  assign win = (ROUND_ROBIN != 0 && any_m) ? idx_m : idx_u;
  assign rel = state == ARB_GRANTED && ((bus.acknowledge[enc_q] && last_credit) || !bus.request[enc_q]);
  assign load = (state == ARB_IDLE || rel) && any_u;
`ifdef RR_ARBITER_REG_WEIGHT_EN
  logic [WEIGHT_W-1:0] credit, next_w;
  assign next_w = bus.weight[win*WEIGHT_W +: WEIGHT_W];
  assign last_credit = credit == WEIGHT_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) credit <= '0;
    else if (load) credit <= next_w == '0 ? WEIGHT_W'(1) : next_w;
    else if (state == ARB_GRANTED && bus.acknowledge[enc_q]) credit <= credit - WEIGHT_W'(1);
`else
  logic unused_weight;
  assign unused_weight = ^bus.weight;
  assign last_credit = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB_IDLE;
      grant_q <= '0;
      enc_q <= '0;
      valid_q <= 1'b0;
      ptr <= PTR_RST;
    end else if (load) begin
      state <= ARB_GRANTED;
      grant_q <= PORTS'(1) << win;
      enc_q <= win;
      valid_q <= 1'b1;
      ptr <= win;
    end else if (rel) begin
      state <= ARB_IDLE;
      grant_q <= '0;
      enc_q <= '0;
      valid_q <= 1'b0;
    end
  assign bus.grant = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_encoded = enc_q;
endmodule

// File: tb/tb_rr_arbiter_reg.sv
// tb_rr_arbiter_reg: directed checks of a round-robin and a fixed-priority instance.
module tb_rr_arbiter_reg;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  rr_arbiter_reg_if #(.PORTS(4), .WEIGHT_W(4)) rr_if ();
  rr_arbiter_reg_if #(.PORTS(4), .WEIGHT_W(4)) fp_if ();
  rr_arbiter_reg #(.PORTS(4), .ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(1), .WEIGHT_W(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr_if));
  rr_arbiter_reg #(.PORTS(4), .ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(1), .WEIGHT_W(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(fp_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rr_if.request = '0; rr_if.acknowledge = '0;
    fp_if.request = '0; fp_if.acknowledge = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rr_if.weight = '0; fp_if.weight = '0;
    rr_if.request = '0; rr_if.acknowledge = '0;
    fp_if.request = '0; fp_if.acknowledge = '0;
    // Reset held with all ports requesting
    rr_if.request = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_grant", rr_if.grant, 4'b0000);
      check("rst_valid", rr_if.grant_valid, 1'b0);
      check("rst_enc", rr_if.grant_encoded, 2'd0);
    end
    // Single requester, held without ack, then released
    do_reset();
    rr_if.request = 4'b0100;
    step();
    check("single_grant", rr_if.grant, 4'b0100);
    check("single_enc", rr_if.grant_encoded, 2'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_grant", rr_if.grant, 4'b0100);
    end
    rr_if.acknowledge = 4'b0100; rr_if.request = 4'b0000;
    step();
    rr_if.acknowledge = 4'b0000;
    check("release_grant", rr_if.grant, 4'b0000);
    check("release_valid", rr_if.grant_valid, 1'b0);
    // Rotation vs fixed priority under full load
    do_reset();
    rr_if.request = 4'b1111; fp_if.request = 4'b1111;
    step();
    check("rr_first", rr_if.grant, 4'b0001);
    check("fp_first", fp_if.grant, 4'b0001);
    begin
      logic [3:0] exp_rr [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0] exp_enc [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
        rr_if.acknowledge = rr_if.grant; fp_if.acknowledge = fp_if.grant;
        step();
        check("rr_rotate", rr_if.grant, exp_rr[i]);
        check("rr_rotate_enc", rr_if.grant_encoded, exp_enc[i]);
        check("fp_fixed", fp_if.grant, 4'b0001);
      end
    end
    rr_if.acknowledge = '0; fp_if.acknowledge = '0;
    // Request drop hands over without a bubble; stray ack ignored
    do_reset();
    rr_if.request = 4'b0010;
    step();
    check("drop_pre", rr_if.grant, 4'b0010);
    rr_if.request = 4'b1000; rr_if.acknowledge = 4'b0001;
    step();
    rr_if.acknowledge = '0;
    check("drop_grant", rr_if.grant, 4'b1000);
    check("drop_valid", rr_if.grant_valid, 1'b1);
    check("drop_enc", rr_if.grant_encoded, 2'd3);
    step();
    check("stray_ack", rr_if.grant, 4'b1000);
    rr_if.request = '0;
    step();
    check("drop_idle", rr_if.grant, 4'b0000);
`ifdef RR_ARBITER_REG_WEIGHT_EN
    // Weighted credits: port 0 gets three acks per turn, weight 0 behaves as 1
    do_reset();
    rr_if.weight = {4'd0, 4'd0, 4'd0, 4'd3};
    rr_if.request = 4'b0011;
    step();
    check("wt_first", rr_if.grant, 4'b0001);
    begin
      logic [3:0] exp_w [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b0001};
      for (int i = 0; i < 4; i++) begin
        rr_if.acknowledge = rr_if.grant;
        step();
        check("wt_seq", rr_if.grant, exp_w[i]);
      end
    end
    rr_if.acknowledge = '0; rr_if.weight = '0;
`endif
    // Async reset mid-grant, then pointer restarts
    do_reset();
    rr_if.request = 4'b0010;
    step();
    check("async_pre", rr_if.grant, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_grant", rr_if.grant, 4'b0000);
    check("async_valid", rr_if.grant_valid, 1'b0);
    rr_if.request = 4'b1010;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_grant", rr_if.grant, 4'b0010);
    check("post_rst_enc", rr_if.grant_encoded, 2'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
